pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the EX-stage

---
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, cache-miss
// freezes, taken-branch/jump IF/ID flushes, stall counter and stuck-stall watchdog.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// RUN       | pipeline advancing (or load-use bubble); flushes may fire
// MEM_STALL | cache miss freeze; branches seen meanwhile are held in flushPend
//
// Leaving MEM_STALL applies the RUN rules in the release cycle itself, so no
// extra bubble is inserted after a freeze.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_RegRs,
  input  logic [4:0]       IFID_RegRt,
  input  logic [4:0]       IDEX_RegRt,
  input  logic             IDEX_MemRead,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ICache_stall,
  input  logic             DCache_stall,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Write,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_timeout
);

  typedef enum logic {RUN, MEM_STALL} state_t;

  state_t          state, stateNext;
  logic            flushPend, flushPendNext;
  logic            mem, lu, br;
  logic            pcWr, ifidWr, ifidFl, idexFl, exmemWr, memwbWr;
  logic [TO_W-1:0] toRemain;

  assign mem = ICache_stall | DCache_stall;
  assign lu  = IDEX_MemRead && (IDEX_RegRt != 5'd0) &&
               ((IDEX_RegRt == IFID_RegRs) || (IDEX_RegRt == IFID_RegRt));
  assign br  = ID_BranchTaken | ID_Jump;

  // State and pending-flush registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flushPend <= 1'b0;
    end else begin
      state     <= stateNext;
      flushPend <= flushPendNext;
    end
  end

  // Next state and enables; priority is mem > load-use > branch.
  always_comb begin
    stateNext     = state;
    flushPendNext = flushPend;
    pcWr          = 1'b1;
    ifidWr        = 1'b1;
    exmemWr       = 1'b1;
    memwbWr       = 1'b1;
    ifidFl        = 1'b0;
    idexFl        = 1'b0;
    if (mem) begin
      // Full freeze from RUN or while already frozen; a branch is remembered.
      pcWr          = 1'b0;
      ifidWr        = 1'b0;
      exmemWr       = 1'b0;
      memwbWr       = 1'b0;
      flushPendNext = flushPend | br;
      stateNext     = MEM_STALL;
    end else begin
      stateNext = RUN;
      if (lu) begin
        // Bubble; the branch in ID re-evaluates next cycle, pending flush waits.
        pcWr   = 1'b0;
        ifidWr = 1'b0;
        idexFl = 1'b1;
      end else begin
        ifidFl        = br | flushPend;
        flushPendNext = 1'b0;
      end
    end
  end

  // Enables are held low for as long as reset is asserted.
  assign PC_Write    = rst_n & pcWr;
  assign IFID_Write  = rst_n & ifidWr;
  assign IFID_Flush  = rst_n & ifidFl;
  assign IDEX_Flush  = rst_n & idexFl;
  assign EXMEM_Write = rst_n & exmemWr;
  assign MEMWB_Write = rst_n & memwbWr;

  // Saturating count of cycles where the PC did not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!pcWr && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  // Watchdog: down-counter reloaded whenever mem drops; terminal count on a mem edge trips it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toRemain      <= TO_W'(TIMEOUT - 1);
      stall_timeout <= 1'b0;
    end else if (mem) begin
      if (toRemain == '0) begin
        stall_timeout <= 1'b1;
      end else begin
        toRemain <= toRemain - TO_W'(1);
      end
    end else begin
      toRemain <= TO_W'(TIMEOUT - 1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand sequences for multi-cycle
// corners, then random stimulus against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 4;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] IFID_RegRs = '0, IFID_RegRt = '0, IDEX_RegRt = '0;
  logic IDEX_MemRead = 0, ID_BranchTaken = 0, ID_Jump = 0, ICache_stall = 0, DCache_stall = 0;
  logic PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write;
  logic [CNT_W-1:0] stall_count;
  logic stall_timeout;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt), .IDEX_RegRt(IDEX_RegRt),
    .IDEX_MemRead(IDEX_MemRead), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .ICache_stall(ICache_stall), .DCache_stall(DCache_stall),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write),
    .stall_count(stall_count), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Model state: pending flush, stall cycles, consecutive mem cycles, watchdog.
  bit mPend;
  int mCount;
  int mConsec;
  bit mTimeout;

  logic [5:0] lastOut;  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write}

  typedef struct {
    logic [4:0] rs, rt, exRt;
    logic       mr, bt, jp, ic, dc;
    logic [5:0] expOut;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Write};
  endfunction

  // One clock cycle: drive inputs, check against model, advance model over the edge.
  task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exRt,
                       input logic mr, input logic bt, input logic jp,
                       input logic ic, input logic dc);
    logic mem, lu, br;
    logic [5:0] exp;
    @(posedge clk); #1;
    IFID_RegRs = rs; IFID_RegRt = rt; IDEX_RegRt = exRt; IDEX_MemRead = mr;
    ID_BranchTaken = bt; ID_Jump = jp; ICache_stall = ic; DCache_stall = dc;
    mem = ic | dc;
    lu  = mr && (exRt != 0) && (exRt == rs || exRt == rt);
    br  = bt | jp;
    if (mem)     exp = 6'b000000;
    else if (lu) exp = 6'b000111;
    else         exp = {2'b11, br | mPend, 3'b011};
    #3;
    lastOut = outs();
    check("outputs", {26'd0, lastOut}, {26'd0, exp});
    check("stall_count", {24'd0, stall_count}, mCount);
    check("stall_timeout", {31'd0, stall_timeout}, {31'd0, mTimeout});
    if (mem) mPend = mPend | br;
    else if (!lu) mPend = 0;
    if ((mem || lu) && mCount < MAXC) mCount++;
    if (mem) begin
      if (mConsec == TIMEOUT - 1) mTimeout = 1;
      mConsec++;
    end else begin
      mConsec = 0;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset in mid-cycle, with inputs that would otherwise enable everything.
  task automatic doReset();
    @(posedge clk); #1;
    IFID_RegRs = 0; IFID_RegRt = 0; IDEX_RegRt = 0; IDEX_MemRead = 0;
    ID_BranchTaken = 0; ID_Jump = 0; ICache_stall = 0; DCache_stall = 0;
    rst_n = 0;
    #1;
    check("reset_outputs", {26'd0, outs()}, 32'd0);
    check("reset_count", {24'd0, stall_count}, 32'd0);
    check("reset_timeout", {31'd0, stall_timeout}, 32'd0);
    mPend = 0; mCount = 0; mConsec = 0; mTimeout = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    tbl[0]  = '{5'd2, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111}; // lw $2, rs=2
    tbl[1]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011}; // $0 dest
    tbl[2]  = '{5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011}; // no match
    tbl[3]  = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111}; // rt match
    tbl[4]  = '{5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011}; // not a load
    tbl[5]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'b111011}; // taken branch
    tbl[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b111011}; // jump
    tbl[7]  = '{5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b000111}; // lu beats br
    tbl[8]  = '{5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000}; // mem beats lu
    tbl[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110011}; // release
    tbl[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000}; // freeze + br
    tbl[11] = '{5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000111}; // release into lu
    tbl[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b111011}; // held flush fires

    doReset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].rs, tbl[i].rt, tbl[i].exRt, tbl[i].mr, tbl[i].bt, tbl[i].jp,
            tbl[i].ic, tbl[i].dc);
      check($sformatf("vector%0d", i), {26'd0, lastOut}, {26'd0, tbl[i].expOut});
    end

    // D-cache miss for 5 cycles, branch in cycle 2; flush on first release cycle.
    doReset();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, (i == 1), 0, 0, 1);
      check("freeze_no_flush", {31'd0, lastOut[3]}, 32'd0);
    end
    idle();
    check("release_flush", {31'd0, lastOut[3]}, 32'd1);
    check("freeze_count", {24'd0, stall_count}, 32'd5);

    // I-cache miss held 6 cycles: watchdog trips on the 4th edge and stays set.
    doReset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      if (i == 3) check("timeout_before", {31'd0, stall_timeout}, 32'd0);
      if (i == 4) check("timeout_after", {31'd0, stall_timeout}, 32'd1);
    end
    idle();
    idle();
    check("timeout_sticky", {31'd0, stall_timeout}, 32'd1);

    // Reset in MEM_STALL with a pending flush: nothing survives.
    doReset();
    cycle(0, 0, 0, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    doReset();
    idle();
    check("post_reset_no_flush", {31'd0, lastOut[3]}, 32'd0);
    check("post_reset_count", {24'd0, stall_count}, 32'd0);

    // Counter saturation.
    doReset();
    for (int i = 0; i < MAXC + 5; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    check("count_saturated", {24'd0, stall_count}, MAXC);

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) doReset();
      cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
